digit_scan: RTL

Time-multiplexed digit scanner for the multi-digit 7-segment display. It latches a packed multi-digit hex value and cycles through the digits at a fixed slot rate. For each slot it presents one 4-bit nibble on `num` to the downstream `decode7` and drives the matching one-hot digit enable. A dark guard interval before each digit suppresses ghosting, and new values take effect only at frame boundaries so the display never tears.

---
 rtl/digit_scan.sv | 116 +++++++++++
 1 files changed

// File: rtl/digit_scan.sv
// digit_scan: time-multiplexed scanner for a multi-digit 7-segment display.
// It latches a packed hex value and steps through the digits one slot at a
// time. Each slot begins with a dark guard interval and then lights the digit.
// A new value reaches the display only at a frame boundary.
// Optional feature: define DIGIT_SCAN_LZB_EN for leading-zero blanking.
module digit_scan #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 50000,
    parameter int GUARD   = 500
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    output logic [3:0]             num,
    output logic [NDIGITS-1:0]     digit,
    output logic                   frame_done
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIGITS);

    typedef enum logic {
        S_GUARD,
        S_SHOW
    } state_t;

    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [4*NDIGITS-1:0] pending, pending_n;
    logic [4*NDIGITS-1:0] shadow, shadow_n;
    logic [3:0]           num_n;
    logic [NDIGITS-1:0]   digit_n;
    logic                 frame_done_n;
    logic                 slot_end;
    logic                 wrap;
`ifdef DIGIT_SCAN_LZB_EN
    logic                 upper_zero;
`endif

    // Next-state logic. The outputs are computed from the next-state values,
    // so the output registers always agree with the state registers.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt + 1'b1;
        pending_n = load ? value : pending;
        shadow_n  = shadow;

        slot_end  = (state == S_SHOW) && (cnt == CW'(DIV - 1));
        wrap      = slot_end && (idx == IW'(NDIGITS - 1));

        case (state)
            S_GUARD: begin
                if (cnt == CW'(GUARD - 1)) begin
                    state_n = S_SHOW;
                end
            end
            S_SHOW: begin
                if (slot_end) begin
                    state_n = S_GUARD;
                    cnt_n   = '0;
                    idx_n   = wrap ? '0 : idx + 1'b1;
                end
            end
            default: state_n = S_GUARD;
        endcase

        // A load in the wrap cycle itself bypasses pending to avoid a lost frame.
        if (wrap) begin
            shadow_n = load ? value : pending;
        end

        frame_done_n = (state_n == S_SHOW) && (idx_n == IW'(NDIGITS - 1)) &&
                       (cnt_n == CW'(DIV - 1));
        num_n        = shadow_n[4*idx_n +: 4];
        digit_n      = (state_n == S_SHOW) ? (NDIGITS'(1) << idx_n) : '0;

`ifdef DIGIT_SCAN_LZB_EN
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if ((i >= 32'(idx_n)) && (shadow_n[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        if (upper_zero && (idx_n != '0)) begin
            digit_n = '0;
        end
`endif
    end

    // State, data and output registers; reset blanks the display at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_GUARD;
            idx        <= '0;
            cnt        <= '0;
            pending    <= '0;
            shadow     <= '0;
            num        <= '0;
            digit      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            pending    <= pending_n;
            shadow     <= shadow_n;
            num        <= num_n;
            digit      <= digit_n;
            frame_done <= frame_done_n;
        end
    end

endmodule
